// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard sequencer.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 6;

    localparam logic [OPC_W-1:0] OPC_J       = 6'h02;
    localparam logic [OPC_W-1:0] OPC_JAL     = 6'h03;
    localparam logic [OPC_W-1:0] OPC_BEQ     = 6'h04;
    localparam logic [OPC_W-1:0] OPC_BNE     = 6'h05;
    localparam logic [OPC_W-1:0] OPC_LB      = 6'h20;
    localparam logic [OPC_W-1:0] OPC_LW      = 6'h23;
    localparam logic [OPC_W-1:0] OPC_SB      = 6'h28;
    localparam logic [OPC_W-1:0] OPC_SW      = 6'h2b;
    localparam logic [OPC_W-1:0] FUNCT_SYSCALL = 6'h0c;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    // A source register conflicts with any in-flight writer; $0 is never a dependency.
    function automatic logic src_hazard(
        input logic [REG_W-1:0] src,
        input logic             used,
        input logic [REG_W-1:0] ex_rd,
        input logic             ex_we,
        input logic [REG_W-1:0] mem_rd,
        input logic             mem_we,
        input logic [REG_W-1:0] wb_rd,
        input logic             wb_we
    );
        return used && (src != '0) &&
               ((ex_we && (ex_rd == src)) ||
                (mem_we && (mem_rd == src)) ||
                (wb_we && (wb_rd == src)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage status in, pipeline control and counters out, between datapath and sequencer.
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic [REG_W-1:0] id_rs_num;
    logic [REG_W-1:0] id_rt_num;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] ex_rd_num;
    logic             ex_reg_we;
    logic [REG_W-1:0] mem_rd_num;
    logic             mem_reg_we;
    logic [REG_W-1:0] wb_rd_num;
    logic             wb_reg_we;
    logic             mem_is_load;
    logic             mem_is_store;
    logic             mem_ready;
    logic             redirect_mem;
    logic             halt_req;

    logic             pc_we;
    logic             hold_front;
    logic             bubble_ex;
    logic             flush_front;
    logic             freeze_all;
    logic             mem_req;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs_num, id_rt_num, id_uses_rs, id_uses_rt,
               ex_rd_num, ex_reg_we, mem_rd_num, mem_reg_we, wb_rd_num, wb_reg_we,
               mem_is_load, mem_is_store, mem_ready, redirect_mem, halt_req,
        input  pc_we, hold_front, bubble_ex, flush_front, freeze_all, mem_req,
               halted, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs_num, id_rt_num, id_uses_rs, id_uses_rt,
               ex_rd_num, ex_reg_we, mem_rd_num, mem_reg_we, wb_rd_num, wb_reg_we,
               mem_is_load, mem_is_store, mem_ready, redirect_mem, halt_req,
        output pc_we, hold_front, bubble_ex, flush_front, freeze_all, mem_req,
               halted, mem_timeout, stall_cycles, flush_count
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencer for a non-forwarding 5-stage MIPS pipeline.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic                 clk,
    input  logic                 rst_b,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            state;
    state_t            state_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nx;
    logic              timeout_q;
    logic              timeout_hit;

    logic              raw_hz;
    logic              mem_acc;
    logic              pc_we;
    logic              hold_front;
    logic              bubble_ex;
    logic              flush_front;
    logic              freeze_all;
    logic              mem_req;
    logic              halted;
    logic              stall_inc;
    logic              flush_inc;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;

    assign raw_hz =
        src_hazard(bus.id_rs_num, bus.id_uses_rs, bus.ex_rd_num, bus.ex_reg_we,
                   bus.mem_rd_num, bus.mem_reg_we, bus.wb_rd_num, bus.wb_reg_we) |
        src_hazard(bus.id_rt_num, bus.id_uses_rt, bus.ex_rd_num, bus.ex_reg_we,
                   bus.mem_rd_num, bus.mem_reg_we, bus.wb_rd_num, bus.wb_reg_we);

    assign mem_acc = bus.mem_is_load | bus.mem_is_store;

    // Priority chain: HALTED > freeze > halt_req > redirect > raw hazard > advance.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = '0;
        timeout_hit = 1'b0;
        pc_we       = 1'b1;
        hold_front  = 1'b0;
        bubble_ex   = 1'b0;
        flush_front = 1'b0;
        freeze_all  = 1'b0;
        mem_req     = 1'b0;
        halted      = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (rst_b) begin
            state_nx = RUN;
        end else if (state == HALTED) begin
            pc_we      = 1'b0;
            freeze_all = 1'b1;
            halted     = 1'b1;
        end else begin
            mem_req = mem_acc;
            if (mem_acc && !bus.mem_ready) begin
                pc_we      = 1'b0;
                freeze_all = 1'b1;
                if (state == RUN) begin
                    state_nx = MEM_WAIT;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nx    = HALTED;
                end else begin
                    wait_cnt_nx = wait_cnt + WAIT_W'(1);
                end
            end else if (bus.halt_req) begin
                pc_we      = 1'b0;
                freeze_all = 1'b1;
                state_nx   = HALTED;
            end else begin
                state_nx = RUN;
                if (bus.redirect_mem) begin
                    flush_front = 1'b1;
                    flush_inc   = 1'b1;
                end else if (raw_hz) begin
                    pc_we      = 1'b0;
                    hold_front = 1'b1;
                    bubble_ex  = 1'b1;
                end
            end
            stall_inc = !pc_we && (state_nx != HALTED);
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state     <= RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst_b),
        .inc (stall_inc),
        .clr (1'b0),
        .q   (stall_q)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst_b),
        .inc (flush_inc),
        .clr (1'b0),
        .q   (flush_q)
    );

    assign bus.pc_we        = pc_we;
    assign bus.hold_front   = hold_front;
    assign bus.bubble_ex    = bubble_ex;
    assign bus.flush_front  = flush_front;
    assign bus.freeze_all   = freeze_all;
    assign bus.mem_req      = mem_req;
    assign bus.halted       = halted;
    assign bus.mem_timeout  = timeout_q;
    assign bus.stall_cycles = stall_q;
    assign bus.flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench for pipeline_hazard_ctrl with an expected-output scoreboard.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W    = 32;
    localparam int unsigned MAX_WAIT = 4;

    // flag order: pc_we hold bubble flush freeze mem_req halted timeout
    localparam logic [7:0] F_IDLE  = 8'b1000_0000;
    localparam logic [7:0] F_RAW   = 8'b0110_0000;
    localparam logic [7:0] F_FLUSH = 8'b1001_0000;
    localparam logic [7:0] F_FRZ   = 8'b0000_1100;
    localparam logic [7:0] F_MEMOK = 8'b1000_0100;
    localparam logic [7:0] F_HREQ  = 8'b0000_1000;
    localparam logic [7:0] F_HALT  = 8'b0000_1010;
    localparam logic [7:0] F_HTO   = 8'b0000_1011;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rs;
        logic       uses_rt;
        logic [4:0] ex_rd;
        logic       ex_we;
        logic [4:0] mem_rd;
        logic       mem_we;
        logic [4:0] wb_rd;
        logic       wb_we;
        logic       ld;
        logic       st;
        logic       rdy;
        logic       redir;
        logic       halt;
    } in_t;

    typedef struct {
        int               id;
        logic [7:0]       flags;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t exp;
    } vec_t;

    logic clk;
    logic rst_b;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];
    vec_t tbl[19];

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input int id, input string what, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL step%0d %s: got %0h want %0h", id, what, act, req);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: no expected entry, got outputs with nothing queued");
            return;
        end
        e = sb.pop_front();
        cmp(e.id, "flags", CNT_W'({bus.pc_we, bus.hold_front, bus.bubble_ex, bus.flush_front,
                                  bus.freeze_all, bus.mem_req, bus.halted, bus.mem_timeout}),
            CNT_W'(e.flags));
        cmp(e.id, "stall_cycles", bus.stall_cycles, e.stall);
        cmp(e.id, "flush_count", bus.flush_count, e.flush);
    endtask

    task automatic apply(input in_t in);
        rst_b            = in.rst;
        bus.id_rs_num    = in.id_rs;
        bus.id_rt_num    = in.id_rt;
        bus.id_uses_rs   = in.uses_rs;
        bus.id_uses_rt   = in.uses_rt;
        bus.ex_rd_num    = in.ex_rd;
        bus.ex_reg_we    = in.ex_we;
        bus.mem_rd_num   = in.mem_rd;
        bus.mem_reg_we   = in.mem_we;
        bus.wb_rd_num    = in.wb_rd;
        bus.wb_reg_we    = in.wb_we;
        bus.mem_is_load  = in.ld;
        bus.mem_is_store = in.st;
        bus.mem_ready    = in.rdy;
        bus.redirect_mem = in.redir;
        bus.halt_req     = in.halt;
    endtask

    // Drive just after the rising edge, check outputs on the falling edge.
    task automatic drive(input in_t in, input int id, input logic [7:0] flags,
                         input int stall, input int flush);
        exp_t e;
        @(posedge clk);
        #1;
        apply(in);
        e.id    = id;
        e.flags = flags;
        e.stall = CNT_W'(stall);
        e.flush = CNT_W'(flush);
        sb.push_back(e);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        in_t idle;
        in_t rsv;
        n_cmp = 0;
        n_bad = 0;
        idle  = '0;
        rsv   = '{rst: 1'b1, default: '0};
        apply(rsv);

        tbl[0]  = '{in: '{default: '0}, exp: '{id: 0, flags: F_IDLE, stall: 0, flush: 0}};
        tbl[1]  = '{in: '{id_rs: 5'd0, uses_rs: 1'b1, ex_rd: 5'd0, ex_we: 1'b1, default: '0},
                    exp: '{id: 1, flags: F_IDLE, stall: 0, flush: 0}};
        tbl[2]  = '{in: '{id_rs: 5'd5, uses_rs: 1'b1, ex_rd: 5'd5, ex_we: 1'b1, default: '0},
                    exp: '{id: 2, flags: F_RAW, stall: 0, flush: 0}};
        tbl[3]  = '{in: '{id_rs: 5'd5, uses_rs: 1'b1, mem_rd: 5'd5, mem_we: 1'b1, default: '0},
                    exp: '{id: 3, flags: F_RAW, stall: 1, flush: 0}};
        tbl[4]  = '{in: '{id_rt: 5'd5, uses_rt: 1'b1, wb_rd: 5'd5, wb_we: 1'b1, default: '0},
                    exp: '{id: 4, flags: F_RAW, stall: 2, flush: 0}};
        tbl[5]  = '{in: '{default: '0}, exp: '{id: 5, flags: F_IDLE, stall: 3, flush: 0}};
        tbl[6]  = '{in: '{id_rs: 5'd7, uses_rs: 1'b0, ex_rd: 5'd7, ex_we: 1'b1, default: '0},
                    exp: '{id: 6, flags: F_IDLE, stall: 3, flush: 0}};
        tbl[7]  = '{in: '{id_rs: 5'd7, uses_rs: 1'b1, ex_rd: 5'd7, ex_we: 1'b0, default: '0},
                    exp: '{id: 7, flags: F_IDLE, stall: 3, flush: 0}};
        tbl[8]  = '{in: '{redir: 1'b1, id_rs: 5'd5, uses_rs: 1'b1, ex_rd: 5'd5, ex_we: 1'b1,
                          default: '0},
                    exp: '{id: 8, flags: F_FLUSH, stall: 3, flush: 0}};
        tbl[9]  = '{in: '{default: '0}, exp: '{id: 9, flags: F_IDLE, stall: 3, flush: 1}};
        tbl[10] = '{in: '{ld: 1'b1, rdy: 1'b1, default: '0},
                    exp: '{id: 10, flags: F_MEMOK, stall: 3, flush: 1}};
        tbl[11] = '{in: '{ld: 1'b1, default: '0}, exp: '{id: 11, flags: F_FRZ, stall: 3, flush: 1}};
        tbl[12] = '{in: '{ld: 1'b1, default: '0}, exp: '{id: 12, flags: F_FRZ, stall: 4, flush: 1}};
        tbl[13] = '{in: '{ld: 1'b1, redir: 1'b1, id_rs: 5'd3, uses_rs: 1'b1, ex_rd: 5'd3,
                          ex_we: 1'b1, default: '0},
                    exp: '{id: 13, flags: F_FRZ, stall: 5, flush: 1}};
        tbl[14] = '{in: '{ld: 1'b1, default: '0}, exp: '{id: 14, flags: F_FRZ, stall: 6, flush: 1}};
        tbl[15] = '{in: '{ld: 1'b1, rdy: 1'b1, default: '0},
                    exp: '{id: 15, flags: F_MEMOK, stall: 7, flush: 1}};
        tbl[16] = '{in: '{default: '0}, exp: '{id: 16, flags: F_IDLE, stall: 7, flush: 1}};
        tbl[17] = '{in: '{id_rt: 5'd9, uses_rt: 1'b1, mem_rd: 5'd9, mem_we: 1'b1, default: '0},
                    exp: '{id: 17, flags: F_RAW, stall: 7, flush: 1}};
        tbl[18] = '{in: '{default: '0}, exp: '{id: 18, flags: F_IDLE, stall: 8, flush: 1}};

        drive(rsv, 100, F_IDLE, 0, 0);
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].in, tbl[i].exp.id, tbl[i].exp.flags,
                  int'(tbl[i].exp.stall), int'(tbl[i].exp.flush));
        end

        // Store that never completes: four MEM_WAIT cycles, then timeout and halt.
        drive('{st: 1'b1, default: '0}, 200, F_FRZ, 8, 1);
        drive('{st: 1'b1, default: '0}, 201, F_FRZ, 9, 1);
        drive('{st: 1'b1, default: '0}, 202, F_FRZ, 10, 1);
        drive('{st: 1'b1, default: '0}, 203, F_FRZ, 11, 1);
        drive('{st: 1'b1, default: '0}, 204, F_FRZ, 12, 1);
        drive('{st: 1'b1, default: '0}, 205, F_HTO, 12, 1);
        drive('{redir: 1'b1, id_rs: 5'd5, uses_rs: 1'b1, ex_rd: 5'd5, ex_we: 1'b1, default: '0},
              206, F_HTO, 12, 1);

        // Reset landing in the middle of a memory wait.
        drive(rsv, 300, F_IDLE, 0, 0);
        drive('{ld: 1'b1, default: '0}, 301, F_FRZ, 0, 0);
        drive('{ld: 1'b1, default: '0}, 302, F_FRZ, 1, 0);
        drive('{ld: 1'b1, default: '0}, 303, F_FRZ, 2, 0);
        drive('{ld: 1'b1, default: '0}, 304, F_FRZ, 3, 0);
        drive('{rst: 1'b1, ld: 1'b1, default: '0}, 305, F_IDLE, 0, 0);
        drive(idle, 306, F_IDLE, 0, 0);
        drive('{ld: 1'b1, rdy: 1'b1, default: '0}, 307, F_MEMOK, 0, 0);

        // halt_req loses to a freeze, then wins once memory completes.
        drive('{ld: 1'b1, halt: 1'b1, default: '0}, 400, F_FRZ, 0, 0);
        drive('{ld: 1'b1, rdy: 1'b1, halt: 1'b1, default: '0}, 401, F_FRZ, 1, 0);
        drive('{ld: 1'b1, id_rs: 5'd4, uses_rs: 1'b1, ex_rd: 5'd4, ex_we: 1'b1, default: '0},
              402, F_HALT, 1, 0);
        drive(idle, 403, F_HALT, 1, 0);

        // Plain halt_req from RUN alongside a hazard.
        drive(rsv, 500, F_IDLE, 0, 0);
        drive('{halt: 1'b1, id_rs: 5'd6, uses_rs: 1'b1, wb_rd: 5'd6, wb_we: 1'b1, default: '0},
              501, F_HREQ, 0, 0);
        drive(idle, 502, F_HALT, 0, 0);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
